shift_issue_stage: RTL and testbench

Execute-stage wrapper around the combinational 32-bit barrel shifter in the RV32I core. It accepts decoded shift instructions (SLL/SRL/SRA/SLLI/SRLI/SRAI) over a valid/ready handshake and decodes direction and arithmetic mode. It registers the shifter operands, drives the shifter, and captures the shifter output into a result register for writeback. It is a two-stage pipeline with full one-per-cycle throughput, backpressure, flush and illegal-encoding reporting.

---
 rtl/shift_issue_stage.sv | 130 +++++++++++++
 tb/tb_shift_issue_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// Execute-stage wrapper for the RV32I barrel shifter: decodes shift ops, registers
// shifter operands (S1) and captures the shifter result for writeback (S2).
module shift_issue_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            is_imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      imm_shamt,
    input  logic [RD_W-1:0] rd,
    output logic [XLEN-1:0] sh_in,
    output logic [4:0]      sh_n,
    output logic            sh_dir,
    output logic            sh_arith,
    input  logic [XLEN-1:0] sh_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            err_valid,
    output logic [RD_W-1:0] err_rd
);

    localparam int unsigned SH_W = 5;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    logic            s1_valid;
    logic [RD_W-1:0] s1_rd;
    logic            s2_valid;

    logic            dec_legal;
    logic            dec_dir;
    logic            dec_arith;
    logic [SH_W-1:0] dec_shamt;

    logic            s2_adv;
    logic            s1_adv;
    logic            accept;
    logic            accept_legal;
    logic            accept_illegal;
    logic [XLEN-1:0] cap_data;

    // Only the low shamt bits of rs2 participate in the shift.
    logic unused_rs2_hi;
    assign unused_rs2_hi = ^rs2_val[XLEN-1:SH_W];

    // Instruction decode: SLL / SRL / SRA, everything else is illegal.
    always_comb begin
        dec_legal = 1'b0;
        dec_dir   = 1'b0;
        dec_arith = 1'b0;
        case (funct3)
            F3_SLL: dec_legal = !funct7_5;
            F3_SR: begin
                dec_legal = 1'b1;
                dec_dir   = 1'b1;
                dec_arith = funct7_5;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_shamt = is_imm ? imm_shamt : rs2_val[SH_W-1:0];

    // Handshake: out_ready ripples combinationally back to in_ready.
    assign s2_adv         = !s2_valid || out_ready;
    assign s1_adv         = !s1_valid || s2_adv;
    assign in_ready       = s1_adv && !flush && !rst;
    assign accept         = in_valid && in_ready;
    assign accept_legal   = accept && dec_legal;
    assign accept_illegal = accept && !dec_legal;

    // Writes to x0 are architecturally discarded, so the result is zeroed.
    assign cap_data  = (s1_rd == RD_W'(0)) ? XLEN'(0) : sh_out;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_rd     <= '0;
            sh_in     <= '0;
            sh_n      <= '0;
            sh_dir    <= 1'b0;
            sh_arith  <= 1'b0;
            s2_valid  <= 1'b0;
            out_data  <= '0;
            out_rd    <= '0;
            err_valid <= 1'b0;
            err_rd    <= '0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            err_valid <= 1'b0;
        end else begin
            err_valid <= accept_illegal;
            if (accept_illegal) begin
                err_rd <= rd;
            end

            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= cap_data;
                    out_rd   <= s1_rd;
                end
            end

            if (s1_adv) begin
                s1_valid <= accept_legal;
                if (accept_legal) begin
                    sh_in    <= rs1_val;
                    sh_n     <= dec_shamt;
                    sh_dir   <= dec_dir;
                    sh_arith <= dec_arith;
                    s1_rd    <= rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Randomized + directed bench for shift_issue_stage against a stage-level reference model.
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_5 = 1'b0;
    logic        is_imm = 1'b0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  imm_shamt = '0;
    logic [4:0]  rd = '0;
    logic [31:0] sh_in;
    logic [4:0]  sh_n;
    logic        sh_dir;
    logic        sh_arith;
    logic [31:0] sh_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        err_valid;
    logic [4:0]  err_rd;

    int n_checks = 0;
    int n_fail   = 0;
    int n_retired = 0;

    always #5 clk = ~clk;

    // Combinational barrel shifter the stage drives.
    assign sh_out = sh_dir ? (sh_arith ? 32'($signed(sh_in) >>> sh_n) : (sh_in >> sh_n))
                           : (sh_in << sh_n);

    shift_issue_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .funct7_5(funct7_5), .is_imm(is_imm), .rs1_val(rs1_val),
        .rs2_val(rs2_val), .imm_shamt(imm_shamt), .rd(rd), .sh_in(sh_in), .sh_n(sh_n),
        .sh_dir(sh_dir), .sh_arith(sh_arith), .sh_out(sh_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .err_valid(err_valid), .err_rd(err_rd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference shift from the ISA definition; sign fill built by masking.
    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [4:0] n,
                                              input logic dir, input logic arith);
        logic [31:0] fill;
        if (!dir) return v << n;
        fill = (arith && v[31]) ? ~(32'hFFFF_FFFF >> n) : 32'h0;
        return (v >> n) | fill;
    endfunction

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } res_t;

    res_t exp_q[$];

    // Model state: what each architectural register must hold after the last edge.
    logic        m_s1v = 1'b0, m_s2v = 1'b0, m_errv = 1'b0;
    logic [31:0] m_sh_in = '0, m_s1res = '0, m_out_data = '0;
    logic [4:0]  m_sh_n = '0, m_s1rd = '0, m_out_rd = '0, m_err_rd = '0;
    logic        m_dir = 1'b0, m_arith = 1'b0;

    always @(negedge clk) begin
        logic exp_ready, acc, legal, s2adv, s1adv;
        logic [4:0] amt;
        res_t r;

        exp_ready = !rst && !flush && (!m_s1v || !m_s2v || out_ready);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_s2v));
        check("out_data", out_data, m_out_data);
        check("out_rd", 32'(out_rd), 32'(m_out_rd));
        check("err_valid", 32'(err_valid), 32'(m_errv));
        if (m_errv) check("err_rd", 32'(err_rd), 32'(m_err_rd));
        check("sh_in", sh_in, m_sh_in);
        check("sh_n", 32'(sh_n), 32'(m_sh_n));
        check("sh_dir", 32'(sh_dir), 32'(m_dir));
        check("sh_arith", 32'(sh_arith), 32'(m_arith));

        // Retirement order against acceptance order.
        if (out_valid && out_ready) begin
            n_retired++;
            if (exp_q.size() == 0) begin
                check("retire_unexpected", 32'(1), 32'(0));
            end else begin
                r = exp_q.pop_front();
                check("order_data", out_data, r.data);
                check("order_rd", 32'(out_rd), 32'(r.rd));
            end
        end

        acc   = in_valid && exp_ready;
        legal = (funct3 == 3'b001 && !funct7_5) || (funct3 == 3'b101);
        amt   = is_imm ? imm_shamt : rs2_val[4:0];
        if (rst) begin
            m_s1v = 0; m_s2v = 0; m_errv = 0; m_sh_in = '0; m_sh_n = '0;
            m_dir = 0; m_arith = 0; m_out_data = '0; m_out_rd = '0; m_err_rd = '0;
            exp_q.delete();
        end else if (flush) begin
            m_s1v = 0; m_s2v = 0; m_errv = 0;
            exp_q.delete();
        end else begin
            s2adv  = !m_s2v || out_ready;
            s1adv  = !m_s1v || s2adv;
            m_errv = acc && !legal;
            if (m_errv) m_err_rd = rd;
            if (s2adv) begin
                if (m_s1v) begin
                    m_out_data = m_s1res;
                    m_out_rd   = m_s1rd;
                end
                m_s2v = m_s1v;
            end
            if (s1adv) begin
                m_s1v = acc && legal;
                if (acc && legal) begin
                    m_sh_in = rs1_val;
                    m_sh_n  = amt;
                    m_dir   = (funct3 == 3'b101);
                    m_arith = (funct3 == 3'b101) && funct7_5;
                    m_s1rd  = rd;
                    m_s1res = (rd == 5'd0) ? 32'h0
                              : ref_shift(rs1_val, amt, m_dir, m_arith);
                    exp_q.push_back('{data: m_s1res, rd: rd});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op and hold it until accepted (bounded).
    task automatic issue(input logic [2:0] f3, input logic f7, input logic imm,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [4:0] d);
        logic acc;
        acc = 1'b0;
        funct3 = f3; funct7_5 = f7; is_imm = imm; rs1_val = a; rs2_val = b;
        imm_shamt = sh; rd = d; in_valid = 1'b1;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!acc) check("issue_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int r0;
        // Reset with junk on the inputs.
        in_valid = 1'b1; funct3 = 3'b001; rs1_val = 32'hDEAD_BEEF; rd = 5'd9;
        repeat (3) step();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        step();
        in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;

        // SLL 1 << 31, two-cycle latency.
        issue(3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_001F, 5'd0, 5'd5);
        @(negedge clk);
        check("sll_lat1", 32'(out_valid), 32'(0));
        @(negedge clk);
        check("sll_valid", 32'(out_valid), 32'(1));
        check("sll_data", out_data, 32'h8000_0000);
        check("sll_rd", 32'(out_rd), 32'(5));
        repeat (3) step();

        // SRAI / SRLI back-to-back.
        issue(3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 5'd1);
        issue(3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 5'd2);
        @(negedge clk);
        check("srai_data", out_data, 32'hF800_0000);
        @(negedge clk);
        check("srli_data", out_data, 32'h0800_0000);
        repeat (3) step();

        // SRL with junk upper rs2 bits, then the x0 variant.
        issue(3'b101, 1'b0, 1'b0, 32'hFFFF_0000, 32'hFFFF_FFE3, 5'd0, 5'd3);
        issue(3'b101, 1'b0, 1'b0, 32'hFFFF_0000, 32'hFFFF_FFE3, 5'd0, 5'd0);
        @(negedge clk);
        check("srl_data", out_data, 32'h1FFF_E000);
        @(negedge clk);
        check("srl_x0_valid", 32'(out_valid), 32'(1));
        check("srl_x0_data", out_data, 32'h0);
        repeat (3) step();

        // Four ops streamed into a stalled writeback.
        r0 = n_retired;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 4; k++)
                    issue(3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'(k), 5'(k));
            end
            begin
                repeat (3) @(negedge clk);
                check("stall_in_ready", 32'(in_ready), 32'(0));
                check("stall_data0", out_data, 32'h2);
                repeat (2) @(negedge clk);
                check("stall_data_hold", out_data, 32'h2);
                check("stall_valid_hold", 32'(out_valid), 32'(1));
                step();
                out_ready = 1'b1;
            end
        join
        repeat (8) step();
        check("stall_retired", 32'(n_retired - r0), 32'(4));

        // Illegal encodings.
        issue(3'b000, 1'b0, 1'b0, 32'h1, 32'h1, 5'd0, 5'd7);
        @(negedge clk);
        check("ill0_err", 32'(err_valid), 32'(1));
        check("ill0_rd", 32'(err_rd), 32'(7));
        check("ill0_noout", 32'(out_valid), 32'(0));
        @(negedge clk);
        check("ill0_pulse", 32'(err_valid), 32'(0));
        step();
        issue(3'b001, 1'b1, 1'b0, 32'h1, 32'h1, 5'd0, 5'd7);
        @(negedge clk);
        check("ill1_err", 32'(err_valid), 32'(1));
        check("ill1_rd", 32'(err_rd), 32'(7));
        repeat (3) step();

        // Flush with two ops in flight.
        r0 = n_retired;
        out_ready = 1'b0;
        issue(3'b001, 1'b0, 1'b0, 32'h3, 32'h1, 5'd0, 5'd10);
        issue(3'b001, 1'b0, 1'b0, 32'h3, 32'h2, 5'd0, 5'd11);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'(0));
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("flush_no_out", 32'(out_valid), 32'(0));
        end
        check("flush_retired", 32'(n_retired - r0), 32'(0));
        step();

        // Reset mid-stall.
        out_ready = 1'b0;
        issue(3'b101, 1'b1, 1'b0, 32'h8765_4321, 32'h4, 5'd0, 5'd12);
        issue(3'b101, 1'b0, 1'b0, 32'h8765_4321, 32'h4, 5'd0, 5'd13);
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rst_mid_valid", 32'(out_valid), 32'(0));
        check("rst_mid_data", out_data, 32'h0);
        check("rst_mid_shin", sh_in, 32'h0);
        check("rst_mid_ready", 32'(in_ready), 32'(0));
        step();
        rst = 1'b0;
        out_ready = 1'b1;

        // Randomized traffic with backpressure, flushes and rare resets.
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] sel;
            sel       = 3'($urandom_range(0, 7));
            funct3    = (sel < 3) ? 3'b001 : (sel < 6) ? 3'b101 : 3'($urandom);
            funct7_5  = ($urandom_range(0, 3) == 0) ? ~funct3[2] : funct3[2] & 1'($urandom);
            is_imm    = 1'($urandom);
            rs1_val   = $urandom;
            rs2_val   = $urandom;
            imm_shamt = 5'($urandom);
            rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 47) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            step();
        end

        // Drain.
        in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        check("drain_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
